dmac_xfer_counter: RTL and testbench
====================================

Name: dmac_xfer_counter

Overview:
Datapath counter stage for one DMA channel. It sits directly upstream of the channel controller and produces the controller's status inputs: bsz (burst complete), tslb (remaining transfer shorter than a burst) and tsz (transfer size zero). It holds the remaining transfer count, the active burst length and the beat counter, and tracks the read/write phase. It is driven by the controller's load and count strobes.

Parameters:
TS_W, 16, width of transfer-size and remaining-count registers (beats)
BL_W, 5, width of burst-length and beat-counter registers; maximum burst is 2^BL_W-1 beats

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
cfg_transfer_size  input  TS_W  total transfer length in beats, from channel config register
cfg_burst_len  input  BL_W  programmed burst length in beats; 0 treated as 1
t_sel  input  1  with ts_en: 1 = load remaining from cfg, 0 = decrement remaining
ts_en  input  1  remaining-count update strobe
burst_en  input  1  active burst-length load strobe
b_sel  input  1  with burst_en: 1 = load tail length (remaining), 0 = load cfg_burst_len
count_en  input  1  one address beat issued this cycle
bsz  output  1  beat_cnt == active burst length (burst complete)
tslb  output  1  remaining != 0 and remaining < effective cfg burst length
tsz  output  1  remaining == 0
phase_wr  output  1  0 = read burst in progress, 1 = write burst in progress
xfer_done  output  1  one-cycle pulse: last beat of final write burst counted
remaining  output  TS_W  beats not yet read
beat_cnt  output  BL_W  beats issued in current burst

Behaviour:
- Reset values (async, rst=1): remaining=0, burst_len_q=1, beat_cnt=0, phase_wr=0, xfer_done=0. Resulting outputs: tsz=1, bsz=0, tslb=0.
- Effective cfg length: eff_bl = (cfg_burst_len==0) ? 1 : cfg_burst_len.
- Remaining register, priority order:
  - ts_en&t_sel: remaining <= cfg_transfer_size.
  - ts_en&!t_sel: remaining <= remaining - burst_len_q, saturating at 0.
  - Otherwise: hold.
- Burst length register:
  - burst_en&!b_sel: burst_len_q <= eff_bl.
  - burst_en&b_sel: burst_len_q <= min(remaining, 2^BL_W-1), with 0 mapped to 1.
  - The value used is the remaining value before any same-cycle ts_en update.
- Beat counter:
  - count_en&bsz: beat_cnt <= 1 (the beat opening the next burst is counted).
  - count_en&!bsz: beat_cnt <= beat_cnt+1.
  - burst_en&!count_en: beat_cnt <= 0.
  - Otherwise: hold.
  - Never exceeds burst_len_q. If a burst_len load makes beat_cnt > burst_len_q, beat_cnt clears to 0.
- Phase FSM, states RD (phase_wr=0) and WR (phase_wr=1):
  - RD->WR on count_en&bsz.
  - WR->RD on count_en&bsz.
  - Any state -> RD on ts_en&t_sel (new transfer).
- xfer_done: registered. Pulses one cycle after a cycle with phase_wr=1, bsz=1, tsz=1 and count_en=0. This is the final write beat seen while the controller returns to DISABLED.
- bsz, tslb, tsz: combinational from registers only. They are valid in the same cycle, and the controller samples them without added latency.
- Simultaneous strobes:
  - All register updates in one cycle use pre-update values.
  - burst_en, ts_en and count_en may all be high together (controller write-to-read turnaround), and each register applies its own rule.
- Reset mid-transfer: all state returns to reset values immediately. There is no partial-count recovery.
- Counts are in beats. Byte scaling belongs to the address generators, not here.

Test Plan:
- Load: rst release; t_sel=1, ts_en=1, cfg_transfer_size=8, burst_en=1, b_sel=0, cfg_burst_len=4 -> next cycle remaining=8, tsz=0, tslb=0, beat_cnt=0, bsz=0.
- Full burst: from load state, count_en for 4 cycles -> beat_cnt 1,2,3,4; bsz=1 at beat_cnt=4. Next count_en with ts_en&!t_sel -> beat_cnt=1, phase_wr=1, remaining=4.
- Tail: size=10, burst=4, run two read/write pairs -> remaining=2, tslb=1. Then burst_en&b_sel&count_en -> burst_len_q=2; bsz asserts after 2 beats.
- Completion: size=4, burst=4, run read burst then write burst with final count_en withheld -> tsz=1 and bsz=1 in phase_wr=1; xfer_done pulses exactly one cycle.
- Zero/edge cfg: cfg_transfer_size=0 load -> tsz=1 next cycle. cfg_burst_len=0 load -> burst_len_q=1, bsz after a single beat. Decrement of remaining=3 by burst_len_q=4 -> remaining=0, no wrap.
- Reset mid-burst: assert rst asynchronously with beat_cnt=2, phase_wr=1 -> all outputs return to reset values before the next clk edge.

Source files
------------

// File: rtl/dmac_xfer_counter.sv
// Per-channel DMA transfer counter: remaining beats, active burst length, beat count
// and read/write phase, producing the bsz/tslb/tsz status flags for the channel controller.
module dmac_xfer_counter #(
   parameter int TS_W = 16,
   parameter int BL_W = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [TS_W-1:0] cfg_transfer_size,
   input  logic [BL_W-1:0] cfg_burst_len,
   input  logic            t_sel,
   input  logic            ts_en,
   input  logic            burst_en,
   input  logic            b_sel,
   input  logic            count_en,
   output logic            bsz,
   output logic            tslb,
   output logic            tsz,
   output logic            phase_wr,
   output logic            xfer_done,
   output logic [TS_W-1:0] remaining,
   output logic [BL_W-1:0] beat_cnt
);

   // state | meaning
   // RD    | read burst in progress (phase_wr=0)
   // WR    | write burst in progress (phase_wr=1)
   typedef enum logic {RD = 1'b0, WR = 1'b1} phase_t;

   localparam logic [BL_W-1:0] BL_ONE = BL_W'(1);
   localparam logic [BL_W-1:0] BL_MAX = '1;

   phase_t          phase_q, phase_d;
   logic [TS_W-1:0] remaining_q, remaining_d;
   logic [BL_W-1:0] burst_len_q, burst_len_d;
   logic [BL_W-1:0] beat_cnt_q, beat_cnt_d;
   logic            xfer_done_q, xfer_done_d;
   logic [BL_W-1:0] eff_bl;
   logic [BL_W-1:0] tail_bl;
   logic [TS_W-1:0] bl_ext;

   assign eff_bl = (cfg_burst_len == '0) ? BL_ONE : cfg_burst_len;
   assign bl_ext = TS_W'(burst_len_q);

   // Tail burst is clamped to the largest encodable burst; an empty remainder still gets one beat.
   always_comb begin
      tail_bl = BL_ONE;
      if (remaining_q > TS_W'(BL_MAX))
         tail_bl = BL_MAX;
      else if (remaining_q != '0)
         tail_bl = remaining_q[BL_W-1:0];
   end

   assign bsz       = (beat_cnt_q == burst_len_q);
   assign tsz       = (remaining_q == '0);
   assign tslb      = !tsz && (remaining_q < TS_W'(eff_bl));
   assign phase_wr  = (phase_q == WR);
   assign xfer_done = xfer_done_q;
   assign remaining = remaining_q;
   assign beat_cnt  = beat_cnt_q;

   always_comb begin
      remaining_d = remaining_q;
      if (ts_en && t_sel)
         remaining_d = cfg_transfer_size;
      else if (ts_en)
         remaining_d = (remaining_q > bl_ext) ? (remaining_q - bl_ext) : '0;
   end

   always_comb begin
      burst_len_d = burst_len_q;
      if (burst_en)
         burst_len_d = b_sel ? tail_bl : eff_bl;
   end

   // The beat that closes one burst is also the first beat of the next, hence reload to 1.
   always_comb begin
      beat_cnt_d = beat_cnt_q;
      if (count_en)
         beat_cnt_d = bsz ? BL_ONE : (beat_cnt_q + BL_ONE);
      else if (burst_en)
         beat_cnt_d = '0;
      if (burst_en && (beat_cnt_d > burst_len_d))
         beat_cnt_d = '0;
   end

   always_comb begin
      phase_d = phase_q;
      if (ts_en && t_sel)
         phase_d = RD;
      else if (count_en && bsz)
         phase_d = (phase_q == RD) ? WR : RD;
   end

   assign xfer_done_d = (phase_q == WR) && bsz && tsz && !count_en;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase_q     <= RD;
         remaining_q <= '0;
         burst_len_q <= BL_ONE;
         beat_cnt_q  <= '0;
         xfer_done_q <= 1'b0;
      end else begin
         phase_q     <= phase_d;
         remaining_q <= remaining_d;
         burst_len_q <= burst_len_d;
         beat_cnt_q  <= beat_cnt_d;
         xfer_done_q <= xfer_done_d;
      end
   end

endmodule

// File: tb/tb_dmac_xfer_counter.sv
// Directed bench for dmac_xfer_counter with hand-computed expectations per scenario.
module tb_dmac_xfer_counter;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] cfg_transfer_size = '0;
   logic [4:0]  cfg_burst_len = '0;
   logic        t_sel = 1'b0, ts_en = 1'b0, burst_en = 1'b0, b_sel = 1'b0, count_en = 1'b0;
   logic        bsz, tslb, tsz, phase_wr, xfer_done;
   logic [15:0] remaining;
   logic [4:0]  beat_cnt;

   int assertions = 0;
   int failures = 0;

   dmac_xfer_counter #(.TS_W(16), .BL_W(5)) dut (
      .clk(clk), .rst(rst),
      .cfg_transfer_size(cfg_transfer_size), .cfg_burst_len(cfg_burst_len),
      .t_sel(t_sel), .ts_en(ts_en), .burst_en(burst_en), .b_sel(b_sel), .count_en(count_en),
      .bsz(bsz), .tslb(tslb), .tsz(tsz), .phase_wr(phase_wr), .xfer_done(xfer_done),
      .remaining(remaining), .beat_cnt(beat_cnt)
   );

   always #5 clk = ~clk;

   task automatic drive(input logic ts, input logic tsel, input logic be, input logic bsel, input logic ce);
      ts_en = ts; t_sel = tsel; burst_en = be; b_sel = bsel; count_en = ce;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [15:0] size, input logic [4:0] bl);
      cfg_transfer_size = size; cfg_burst_len = bl;
      drive(1, 1, 1, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0);
   endtask

   task automatic test_reset();
      #1 rst = 1'b1;
      tick();
      assertions++; if (remaining !== 16'd0) begin failures++; $display("FAIL reset_remaining got %0d exp 0", remaining); end
      assertions++; if (beat_cnt !== 5'd0) begin failures++; $display("FAIL reset_beat got %0d exp 0", beat_cnt); end
      assertions++; if ({tsz, bsz, tslb, phase_wr, xfer_done} !== 5'b10000) begin failures++; $display("FAIL reset_flags got %b exp 10000", {tsz, bsz, tslb, phase_wr, xfer_done}); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_load();
      load(16'd8, 5'd4);
      assertions++; if (remaining !== 16'd8) begin failures++; $display("FAIL load_remaining got %0d exp 8", remaining); end
      assertions++; if (beat_cnt !== 5'd0) begin failures++; $display("FAIL load_beat got %0d exp 0", beat_cnt); end
      assertions++; if ({tsz, tslb, bsz, phase_wr} !== 4'b0000) begin failures++; $display("FAIL load_flags got %b exp 0000", {tsz, tslb, bsz, phase_wr}); end
   endtask

   task automatic test_full_burst();
      for (int i = 1; i <= 4; i++) begin
         drive(0, 0, 0, 0, 1);
         tick();
         assertions++; if (beat_cnt !== 5'(i)) begin failures++; $display("FAIL burst_beat%0d got %0d exp %0d", i, beat_cnt, i); end
         assertions++; if (bsz !== (i == 4)) begin failures++; $display("FAIL burst_bsz%0d got %b exp %b", i, bsz, (i == 4)); end
         assertions++; if (phase_wr !== 1'b0) begin failures++; $display("FAIL burst_phase%0d got %b exp 0", i, phase_wr); end
      end
      drive(1, 0, 0, 0, 1);
      tick();
      drive(0, 0, 0, 0, 0);
      assertions++; if (beat_cnt !== 5'd1) begin failures++; $display("FAIL turn_beat got %0d exp 1", beat_cnt); end
      assertions++; if (phase_wr !== 1'b1) begin failures++; $display("FAIL turn_phase got %b exp 1", phase_wr); end
      assertions++; if (remaining !== 16'd4) begin failures++; $display("FAIL turn_remaining got %0d exp 4", remaining); end
   endtask

   task automatic test_tail();
      load(16'd10, 5'd4);
      for (int pair = 0; pair < 2; pair++) begin
         // read burst: opening beat (pair>0 opens on previous write's last beat), then rest
         for (int i = 0; i < ((pair == 0) ? 4 : 3); i++) begin drive(0, 0, 0, 0, 1); tick(); end
         drive(1, 0, 0, 0, 1); tick();
         for (int i = 0; i < 3; i++) begin drive(0, 0, 0, 0, 1); tick(); end
         if (pair == 0) begin drive(0, 0, 0, 0, 1); tick(); end
      end
      drive(0, 0, 0, 0, 0);
      assertions++; if (remaining !== 16'd2) begin failures++; $display("FAIL tail_remaining got %0d exp 2", remaining); end
      assertions++; if ({tslb, bsz, phase_wr} !== 3'b111) begin failures++; $display("FAIL tail_flags got %b exp 111", {tslb, bsz, phase_wr}); end
      drive(0, 0, 1, 1, 1);
      tick();
      assertions++; if ({beat_cnt, bsz, phase_wr} !== {5'd1, 2'b00}) begin failures++; $display("FAIL tail_open got beat %0d bsz %b ph %b exp 1 0 0", beat_cnt, bsz, phase_wr); end
      drive(0, 0, 0, 0, 1);
      tick();
      drive(0, 0, 0, 0, 0);
      assertions++; if ({beat_cnt, bsz} !== {5'd2, 1'b1}) begin failures++; $display("FAIL tail_end got beat %0d bsz %b exp 2 1", beat_cnt, bsz); end
   endtask

   task automatic test_completion();
      load(16'd4, 5'd4);
      for (int i = 0; i < 4; i++) begin drive(0, 0, 0, 0, 1); tick(); end
      drive(1, 0, 0, 0, 1); tick();
      for (int i = 0; i < 3; i++) begin drive(0, 0, 0, 0, 1); tick(); end
      drive(0, 0, 0, 0, 0);
      assertions++; if ({tsz, bsz, phase_wr, xfer_done} !== 4'b1110) begin failures++; $display("FAIL done_pre got %b exp 1110", {tsz, bsz, phase_wr, xfer_done}); end
      tick();
      assertions++; if (xfer_done !== 1'b1) begin failures++; $display("FAIL done_pulse got %b exp 1", xfer_done); end
      drive(0, 0, 0, 0, 1);
      tick();
      drive(0, 0, 0, 0, 0);
      assertions++; if ({xfer_done, phase_wr} !== 2'b00) begin failures++; $display("FAIL done_clear got %b exp 00", {xfer_done, phase_wr}); end
   endtask

   task automatic test_edge();
      load(16'd0, 5'd0);
      assertions++; if ({tsz, tslb, bsz} !== 3'b100) begin failures++; $display("FAIL zero_flags got %b exp 100", {tsz, tslb, bsz}); end
      drive(0, 0, 0, 0, 1);
      tick();
      drive(0, 0, 0, 0, 0);
      assertions++; if ({beat_cnt, bsz} !== {5'd1, 1'b1}) begin failures++; $display("FAIL bl0_beat got beat %0d bsz %b exp 1 1", beat_cnt, bsz); end
      load(16'd3, 5'd4);
      assertions++; if (tslb !== 1'b1) begin failures++; $display("FAIL short_tslb got %b exp 1", tslb); end
      drive(1, 0, 0, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0);
      assertions++; if ({remaining, tsz} !== {16'd0, 1'b1}) begin failures++; $display("FAIL sat_remaining got %0d tsz %b exp 0 1", remaining, tsz); end
   endtask

   task automatic test_reset_mid();
      load(16'd8, 5'd4);
      for (int i = 0; i < 4; i++) begin drive(0, 0, 0, 0, 1); tick(); end
      drive(1, 0, 0, 0, 1); tick();
      drive(0, 0, 0, 0, 1); tick();
      drive(0, 0, 0, 0, 0);
      assertions++; if ({beat_cnt, phase_wr} !== {5'd2, 1'b1}) begin failures++; $display("FAIL mid_setup got beat %0d ph %b exp 2 1", beat_cnt, phase_wr); end
      #2 rst = 1'b1;
      #1;
      assertions++; if ({remaining, beat_cnt} !== {16'd0, 5'd0}) begin failures++; $display("FAIL mid_counts got rem %0d beat %0d exp 0 0", remaining, beat_cnt); end
      assertions++; if ({tsz, bsz, tslb, phase_wr, xfer_done} !== 5'b10000) begin failures++; $display("FAIL mid_flags got %b exp 10000", {tsz, bsz, tslb, phase_wr, xfer_done}); end
      tick();
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_load();
      test_full_burst();
      test_tail();
      test_completion();
      test_edge();
      test_reset_mid();
      tick();
      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end

endmodule
